// File: rtl/pipe_pkg.sv
// Shared pipeline payload definitions: EX/MEM field widths, bit offsets and packed struct.
package pipe_pkg;

    localparam int unsigned OP_C_W    = 32;
    localparam int unsigned WADDR_W   = 5;
    localparam int unsigned WE_W      = 1;
    localparam int unsigned MTYPE_W   = 1;
    localparam int unsigned RW_W      = 1;
    localparam int unsigned WIDTH_W   = 2;
    localparam int unsigned WR_DATA_W = 32;
    localparam int unsigned RDTYPE_W  = 1;
    localparam int unsigned ADDR_W    = 32;

    // Offsets within the flat vector, addr at the bottom and op_c at the top
    localparam int unsigned ADDR_LSB    = 0;
    localparam int unsigned RDTYPE_LSB  = ADDR_LSB + ADDR_W;
    localparam int unsigned WR_DATA_LSB = RDTYPE_LSB + RDTYPE_W;
    localparam int unsigned WIDTH_LSB   = WR_DATA_LSB + WR_DATA_W;
    localparam int unsigned RW_LSB      = WIDTH_LSB + WIDTH_W;
    localparam int unsigned MTYPE_LSB   = RW_LSB + RW_W;
    localparam int unsigned WE_LSB      = MTYPE_LSB + MTYPE_W;
    localparam int unsigned WADDR_LSB   = WE_LSB + WE_W;
    localparam int unsigned OP_C_LSB    = WADDR_LSB + WADDR_W;

    localparam int unsigned EXMEM_W = 107;

    typedef struct packed {
        logic [OP_C_W-1:0]    op_c;
        logic [WADDR_W-1:0]   waddr;
        logic                 we;
        logic                 mtype;
        logic                 rw;
        logic [WIDTH_W-1:0]   width;
        logic [WR_DATA_W-1:0] wr_data;
        logic                 rdtype;
        logic [ADDR_W-1:0]    addr;
    } exmem_payload_t;

endpackage

// File: rtl/pipe_stall_cnt.sv
// Saturating cycle counter with synchronous clear (clear wins) and increment enable.
module pipe_stall_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush, stall and stall-cycle counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry so up_ready_o comes from a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W   = EXMEM_W,
    parameter logic [DATA_W-1:0]  DATA_RST = '0,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              dn_fire;
    logic              up_fire;

    assign dn_fire = valid_q & dn_ready_i & ~stall_i;
    assign up_fire = up_valid_i & up_ready_o;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Ready depends only on the skid flop (flush just opens the door while discarding)
    assign up_ready_o = ~skid_valid_q | flush_i;

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (dn_fire) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                data_d       = skid_data_q;
                skid_valid_d = up_fire;
                if (up_fire) begin
                    skid_data_d = up_data_i;
                end
            end else if (up_fire) begin
                valid_d = 1'b1;
                data_d  = up_data_i;
            end else begin
                valid_d = 1'b0;
            end
        end else if (up_fire) begin
            // Main busy and not draining: park the beat behind it
            if (valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = up_data_i;
            end else begin
                valid_d = 1'b1;
                data_d  = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= DATA_RST;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign up_ready_o = ~valid_q | (dn_ready_i & ~stall_i) | flush_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (up_fire) begin
            valid_d = 1'b1;
            data_d  = up_data_i;
        end else if (dn_fire) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= DATA_RST;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    pipe_stall_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_i),
        .inc_i (valid_q & ~dn_fire & ~flush_i),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic vs a queue model.
module tb_pipe_stage_reg;

    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 4;
    localparam logic [DW-1:0] RST_VAL = 8'hC3;
    localparam int CNT_MAX = 15;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          up_valid_i, up_ready_o, dn_valid_o, dn_ready_i;
    logic [DW-1:0] up_data_i, dn_data_o;
    logic          stall_i, flush_i, cnt_clr_i;
    logic [CW-1:0] stall_cnt_o;

    pipe_stage_reg #(
        .DATA_W   (DW),
        .DATA_RST (RST_VAL),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_data_i   (up_data_i),
        .dn_valid_o  (dn_valid_o),
        .dn_ready_i  (dn_ready_i),
        .dn_data_o   (dn_data_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .cnt_clr_i   (cnt_clr_i),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: FIFO of held beats, last beat seen at the head, and a stall count
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_head;
    int            m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic model_ready();
        if (flush_i) return 1'b1;
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || (dn_ready_i && !stall_i);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_head = RST_VAL;
        m_cnt  = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_dn_valid"}, 32'(dn_valid_o), 32'(mq.size() > 0));
        chk({tag, "_dn_data"}, 32'(dn_data_o), 32'(m_head));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt_o), 32'(m_cnt));
    endtask

    // One clock cycle: drive, check ready, clock, update model, check registered outputs
    task automatic step(input logic uv, input logic [DW-1:0] ud, input logic dr,
                        input logic st, input logic fl, input logic cl, input string tag);
        logic rdy, fire_dn, fire_up;
        up_valid_i = uv; up_data_i = ud; dn_ready_i = dr;
        stall_i = st; flush_i = fl; cnt_clr_i = cl;
        #1;
        rdy = model_ready();
        chk({tag, "_up_ready"}, 32'(up_ready_o), 32'(rdy));
        fire_dn = (mq.size() > 0) && dr && !st;
        fire_up = uv && rdy;
        @(posedge clk);
        if (cl) m_cnt = 0;
        else if ((mq.size() > 0) && !fire_dn && !fl && m_cnt < CNT_MAX) m_cnt++;
        if (fl) begin
            mq.delete();
        end else begin
            if (fire_dn) void'(mq.pop_front());
            if (fire_up) mq.push_back(ud);
        end
        if (mq.size() > 0) m_head = mq[0];
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1;
        up_valid_i = 1'b0; up_data_i = '0; dn_ready_i = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset_up_ready", 32'(up_ready_o), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single beat with 1-cycle latency
        step(1'b1, 8'h15, 1'b1, 1'b0, 1'b0, 1'b0, "single");
        chk("single_valid", 32'(dn_valid_o), 32'd1);
        chk("single_data", 32'(dn_data_o), 32'h15);
        idle("single_drain");
        chk("single_gone", 32'(dn_valid_o), 32'd0);

        // Stall hold for 5 cycles then one transfer
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, "hold_fill");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "hold");
            chk("hold_data", 32'(dn_data_o), 32'hAA);
`ifndef PIPE_STAGE_SKID_EN
            chk("hold_up_ready", 32'(up_ready_o), 32'd0);
`endif
        end
        chk("hold_cnt5", 32'(stall_cnt_o), 32'd5);
        idle("hold_release");
        chk("hold_released", 32'(dn_valid_o), 32'd0);
        idle("hold_after");

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, "stream");
            chk("stream_valid", 32'(dn_valid_o), 32'd1);
            chk("stream_data", 32'(dn_data_o), 32'(i));
        end
        idle("stream_end");

        // Counter saturation then clear during a stall cycle
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, "sat_fill");
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "sat");
        chk("sat_cnt15", 32'(stall_cnt_o), 32'd15);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, "sat_clr");
        chk("sat_cleared", 32'(stall_cnt_o), 32'd0);

        // Flush during stall with an incoming beat
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, "flush_fill");
        chk("flush_full", 32'(dn_data_o), 32'h33);
        step(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, "flush");
        chk("flush_invalid", 32'(dn_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle("flush_after");
            chk("flush_no_44", 32'(dn_valid_o), 32'd0);
            chk("flush_data_held", 32'(dn_data_o), 32'h33);
        end

`ifdef PIPE_STAGE_SKID_EN
        // Skid entry absorbs one beat while downstream is blocked
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, "skid_main");
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, "skid_push");
        chk("skid_not_ready", 32'(up_ready_o), 32'd0);
        chk("skid_out1", 32'(dn_data_o), 32'h01);
        idle("skid_drain1");
        chk("skid_out2", 32'(dn_data_o), 32'h02);
        chk("skid_ready_back", 32'(up_ready_o), 32'd1);
        idle("skid_drain2");
`endif

        // Reset mid-transfer loses the held beat
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, "mid_fill");
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        idle("mid_after");

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 15) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
